// File: rtl/sram_frame_writer.sv
// Burst writer that streams valid/ready words into an asynchronous SRAM at one word per three cycles.
// Optional running checksum of written words is enabled by defining SRAM_FRAME_WRITER_CHECKSUM_EN.
module sram_frame_writer #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_word_count,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_sram_writing,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_checksum,
  output logic [2:0]        o_state
);

  // Handshake: a word moves on any rising edge where i_valid and o_ready are both
  // high; o_ready depends only on the state register, never on i_valid.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_WRITE   = 3'd2,
    S_RECOVER = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_data;
  logic              r_abort_pend;
  logic              w_accept;
  logic              w_xfer;
  logic              w_leave_recover;

  assign w_accept        = (r_state == S_IDLE) && i_start;
  assign w_xfer          = i_valid && o_ready;
  assign w_leave_recover = (r_state == S_RECOVER);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = (i_word_count == '0) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (i_abort)      w_next = S_IDLE;
        else if (i_valid) w_next = S_WRITE;
      end
      S_WRITE:   w_next = S_RECOVER;
      // An abort seen during WRITE or RECOVER lets the word finish, then drops to IDLE.
      S_RECOVER: begin
        if (r_abort_pend || i_abort)      w_next = S_IDLE;
        else if (r_count == ADDR_W'(1))   w_next = S_DONE;
        else                              w_next = S_WAIT;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr       <= '0;
      r_count      <= '0;
      r_data       <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_accept && (i_word_count != '0)) begin
        r_addr  <= i_base_addr;
        r_count <= i_word_count;
      end
      if (w_accept) r_abort_pend <= 1'b0;
      if (w_xfer) r_data <= i_data;
      if ((r_state == S_WRITE) && i_abort) r_abort_pend <= 1'b1;
      if (w_leave_recover) begin
        r_addr       <= r_addr + ADDR_W'(1);
        r_count      <= r_count - ADDR_W'(1);
        r_abort_pend <= 1'b0;
      end
    end
  end

`ifdef SRAM_FRAME_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge i_clk) begin
    if (i_rst)                      r_checksum <= '0;
    else if (w_accept)              r_checksum <= '0;
    else if (r_state == S_WRITE)    r_checksum <= r_checksum + r_data;
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

  assign o_ready        = (r_state == S_WAIT);
  assign o_sram_writing = (r_state == S_WRITE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_sram_addr    = r_addr;
  assign o_sram_data    = r_data;
  assign o_state        = r_state;

endmodule

// File: tb/tb_sram_frame_writer.sv
// Directed bench for sram_frame_writer: scoreboard of expected SRAM writes checked by a strobe monitor.
// Checksum expectations follow SRAM_FRAME_WRITER_CHECKSUM_EN when defined for the build.
module tb_sram_frame_writer;
  localparam int AW = 20;
  localparam int DW = 16;

  logic          i_clk;
  logic          i_rst;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [AW-1:0] i_word_count;
  logic          i_abort;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic          o_sram_writing;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_data;
  logic          o_busy;
  logic          o_done;
  logic [DW-1:0] o_checksum;
  logic [2:0]    o_state;

  sram_frame_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_word_count(i_word_count), .i_abort(i_abort), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_sram_writing(o_sram_writing), .o_sram_addr(o_sram_addr),
    .o_sram_data(o_sram_data), .o_busy(o_busy), .o_done(o_done), .o_checksum(o_checksum),
    .o_state(o_state)
  );

  // clock / reset block
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  logic [AW+DW-1:0] exp_q[$];
  int               wr_cyc[$];
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               strobes = 0;
  int               done_cnt = 0;
  logic             rst_at_edge = 1'b0;
  logic             prev_wr = 1'b0;
  logic [AW-1:0]    prev_addr = '0;
  logic [DW-1:0]    prev_data = '0;
  logic [DW-1:0]    sum_model = '0;
  logic [AW-1:0]    next_addr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_ck();
`ifdef SRAM_FRAME_WRITER_CHECKSUM_EN
    return sum_model;
`else
    return '0;
`endif
  endfunction

  always @(posedge i_clk) begin
    cyc++;
    rst_at_edge = i_rst;
  end

  // strobe monitor: pops the scoreboard on each write strobe and checks the hold cycle after it
  always @(negedge i_clk) begin
    if (o_done) done_cnt++;
    if (prev_wr && !rst_at_edge)
      check("recover_hold", {o_sram_addr, o_sram_data}, {prev_addr, prev_data});
    if (o_sram_writing) begin
      strobes++;
      wr_cyc.push_back(cyc);
      check("no_back_to_back", prev_wr, 1'b0);
      check("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("sram_write", {o_sram_addr, o_sram_data}, exp_q.pop_front());
    end
    prev_wr   = o_sram_writing;
    prev_addr = o_sram_addr;
    prev_data = o_sram_data;
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!o_ready && n < 50) begin
      tick();
      n++;
    end
    check(tag, o_ready, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 50) begin
      tick();
      n++;
    end
    check(tag, o_done, 1'b1);
  endtask

  task automatic start_burst(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
    i_base_addr  = base;
    i_word_count = cnt;
    i_start      = 1'b1;
    next_addr    = base;
    sum_model    = '0;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    i_data  = d;
    i_valid = 1'b1;
    exp_q.push_back({next_addr, d});
    sum_model = sum_model + d;
    next_addr = next_addr + AW'(1);
    wait_ready("ready_before_word");
    tick();
    check("strobe_after_xfer", o_sram_writing, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {o_sram_writing, o_ready, o_busy, o_done}, 4'b0000);
    check({tag, "_addr"}, o_sram_addr, '0);
    check({tag, "_data"}, o_sram_data, '0);
    check({tag, "_cksum"}, o_checksum, '0);
  endtask

  initial begin
    int d0;
    int s0;
    i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_word_count = '0;
    i_abort = 1'b0; i_data = '0; i_valid = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    i_rst = 1'b0;
    tick();

    // basic burst, valid held high
    wr_cyc.delete();
    start_burst(20'h00010, 20'd3);
    check("wait_addr_is_base", o_sram_addr, 20'h00010);
    check("ready_in_wait", o_ready, 1'b1);
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    wait_done("basic_done");
    check("basic_strobes", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      check("basic_gap1", wr_cyc[1] - wr_cyc[0], 3);
      check("basic_gap2", wr_cyc[2] - wr_cyc[1], 3);
      // done lands in the ninth cycle counting the first WRITE cycle as cycle one
      check("basic_done_latency", cyc - wr_cyc[0], 8);
    end
    check("basic_cksum", o_checksum, exp_ck());
    tick();
    check("done_one_cycle", {o_done, o_busy}, 2'b00);
    check("cksum_held", o_checksum, exp_ck());

    // zero count
    s0 = strobes; d0 = done_cnt;
    start_burst(20'h00055, 20'd0);
    check("zero_done_busy", {o_done, o_busy, o_sram_writing}, 3'b110);
    tick();
    check("zero_idle", {o_done, o_busy}, 2'b00);
    check("zero_no_strobe", strobes - s0, 0);
    check("zero_done_count", done_cnt - d0, 1);

    // wrap and backpressure, also the checksum overflow case
    start_burst(20'hFFFFF, 20'd2);
    send_word(16'hFFFF);
    i_valid = 1'b0;
    wait_ready("bp_ready");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready_held", {o_ready, o_sram_writing}, 2'b10);
    end
    check("bp_wrapped_addr", o_sram_addr, 20'h00000);
    send_word(16'h0002);
    i_valid = 1'b0;
    wait_done("wrap_done");
    check("wrap_cksum", o_checksum, exp_ck());
    tick();

    // abort during the RECOVER of word 2
    s0 = strobes; d0 = done_cnt;
    start_burst(20'h00200, 20'd4);
    send_word(16'hA001);
    send_word(16'hA002);
    tick();
    check("abort_in_recover", {o_sram_writing, o_busy, o_ready}, 3'b010);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    i_valid = 1'b0;
    check("abort_idle", o_busy, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("abort_strobes", strobes - s0, 2);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_sb_empty", exp_q.size(), 0);

    // start wins over abort in the same IDLE cycle
    i_abort = 1'b1;
    start_burst(20'h00300, 20'd1);
    i_abort = 1'b0;
    check("start_over_abort", {o_busy, o_ready}, 2'b11);
    check("restart_addr", o_sram_addr, 20'h00300);
    send_word(16'hABCD);
    i_valid = 1'b0;
    wait_done("restart_done");
    tick();

    // reset during WRITE, then reset with start while IDLE
    start_burst(20'h00040, 20'd2);
    send_word(16'h5555);
    i_valid = 1'b0;
    i_rst = 1'b1;
    i_start = 1'b1;
    tick();
    check_all_zero("rst_mid_write");
    tick();
    check("rst_start_ignored", o_busy, 1'b0);
    i_rst = 1'b0;
    i_start = 1'b0;
    tick();
    check("after_rst_idle", {o_busy, o_ready}, 2'b00);
    check("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
